// File: rtl/dist_accum.sv
// Float32 distance accumulator: sums NUM_FEAT non-negative terms per distance and presents each
// result with a wrapping sequence index; the result is held until the consumer takes it.
module dist_accum #(
  parameter int NUM_FEAT = 4,
  parameter int IDX_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx
);

  localparam int CNT_W = $clog2(NUM_FEAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEAT - 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sum;
  logic [31:0]      acc_next;

  // Single-precision add: align to the larger exponent, truncate, renormalise, no rounding.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, r;
    logic [8:0]  ea, eb, diff, er, sh;
    logic [23:0] ma, mb, mbs, dm, nm;
    logic [24:0] sm;
    logic [4:0]  lz;
    if (x[30:0] >= y[30:0]) begin
      a = x;
      b = y;
    end else begin
      a = y;
      b = x;
    end
    ea   = (a[30:23] == 8'd0) ? 9'd1 : {1'b0, a[30:23]};
    eb   = (b[30:23] == 8'd0) ? 9'd1 : {1'b0, b[30:23]};
    ma   = {|a[30:23], a[22:0]};
    mb   = {|b[30:23], b[22:0]};
    diff = ea - eb;
    mbs  = (diff > 9'd23) ? 24'd0 : (mb >> diff);
    r    = '0;
    sm   = '0;
    dm   = '0;
    nm   = '0;
    lz   = '0;
    er   = '0;
    sh   = '0;
    if (a[31] == b[31]) begin
      sm = {1'b0, ma} + {1'b0, mbs};
      if (sm[24]) begin
        er = ea + 9'd1;
        if (er >= 9'd255)
          r = {a[31], 8'hFF, 23'd0};
        else
          r = {a[31], er[7:0], sm[23:1]};
      end else if (sm[23]) begin
        r = {a[31], ea[7:0], sm[22:0]};
      end else begin
        r = {a[31], 8'd0, sm[22:0]};
      end
    end else begin
      dm = ma - mbs;
      lz = 5'd24;
      for (int i = 0; i < 24; i++)
        if (dm[i]) lz = 5'(23 - i);
      if (dm == 24'd0) begin
        r = '0;
      end else if ({4'd0, lz} < ea) begin
        er = ea - {4'd0, lz};
        nm = dm << lz;
        r  = {a[31], er[7:0], nm[22:0]};
      end else begin
        // Result underflows to a denormal: shift only as far as the minimum exponent allows.
        sh = ea - 9'd1;
        nm = dm << sh;
        r  = {a[31], 8'd0, nm[22:0]};
      end
    end
    return r;
  endfunction

  assign sum = fp_add(acc, in_data);

  always_comb begin
    acc_next = sum;
    if (cnt == '0)
      acc_next = in_data;
    else if (in_data == 32'h0000_0000)
      acc_next = acc;
    else if (acc == 32'h0000_0000)
      acc_next = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (flush) begin
            acc <= '0;
            cnt <= '0;
          end else if (in_valid && in_ready) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state     <= DONE;
              out_data  <= acc_next;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        DONE: begin
          // flush is deliberately ignored here: the pending distance survives until consumed.
          if (out_valid && out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_idx   <= out_idx + 1'b1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dist_accum.sv
// Bench for dist_accum: directed scenarios plus randomized distances checked against exact arithmetic.
module tb_dist_accum;

  localparam int NF = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [IW-1:0] out_idx;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [IW-1:0] exp_idx;

  always #5 clk = ~clk;

  dist_accum #(.NUM_FEAT(NF), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx)
  );

  // Exact float32 encoding of n * 2^-s for n < 2^24 (such sums never need truncation).
  function automatic logic [31:0] to_f32(input int unsigned n, input int s);
    int          p;
    int          e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (n[i]) p = i;
    m = 32'(n) << (23 - p);
    e = 127 + p - s;
    return {1'b0, 8'(e), m[22:0]};
  endfunction

  task automatic send_term(input logic [31:0] d, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      to       = 1'b1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] t [4], output bit to);
    bit t1;
    to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_term(t[i], t1);
      to = to | t1;
    end
  endtask

  task automatic get_out(output logic [31:0] d, output logic [IW-1:0] idx, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      to  = 1'b1;
      d   = 'x;
      idx = 'x;
      return;
    end
    d         = out_data;
    idx       = out_idx;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h4000_0000;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_idx   = '0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h4000_0000;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_idx   = '0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    n_checks++; if (out_idx !== '0) begin n_fail++; $display("FAIL reset_out_idx: got %h expected 00", out_idx); end
  endtask

  task automatic test_basic();
    logic [31:0]   t [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    logic [31:0]   d;
    logic [IW-1:0] idx;
    bit            to;
    bit            t1;
    for (int i = 0; i < 3; i++) begin
      send_term(t[i], t1);
      to = to | t1;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
    send_term(t[3], t1);
    to = to | t1;
    n_checks++; if (out_valid !== 1'b1 || to) begin n_fail++; $display("FAIL basic_latency: out_valid %b timeout %b expected 1 0", out_valid, to); end
    get_out(d, idx, to);
    n_checks++; if (to || d !== 32'h4120_0000) begin n_fail++; $display("FAIL basic_data: got %h expected 41200000", d); end
    n_checks++; if (idx !== exp_idx) begin n_fail++; $display("FAIL basic_idx: got %h expected %h", idx, exp_idx); end
    exp_idx++;
  endtask

  task automatic test_backpressure();
    logic [31:0] t [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    bit          to;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      send_term(t[i], to);
      n_checks++; if (to) begin n_fail++; $display("FAIL bp_send_timeout: got timeout expected accept"); end
    end
    in_valid = 1'b1;
    in_data  = 32'h7F00_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h4120_0000 || in_ready !== 1'b0 || out_idx !== exp_idx) begin
        n_fail++;
        $display("FAIL bp_hold: valid %b data %h ready %b idx %h expected 1 41200000 0 %h",
                 out_valid, out_data, in_ready, out_idx, exp_idx);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_idx++;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== exp_idx) begin
      n_fail++;
      $display("FAIL bp_after_consume: ready %b valid %b idx %h expected 1 0 %h", in_ready, out_valid, out_idx, exp_idx);
    end
  endtask

  task automatic test_zeros();
    logic [31:0]   t [4] = '{32'h0, 32'h3F80_0000, 32'h0, 32'h3F80_0000};
    logic [31:0]   d;
    logic [IW-1:0] idx;
    bit            to;
    send4(t, to);
    get_out(d, idx, to);
    n_checks++; if (to || d !== 32'h4000_0000) begin n_fail++; $display("FAIL zeros_data: got %h expected 40000000", d); end
    n_checks++; if (idx !== exp_idx) begin n_fail++; $display("FAIL zeros_idx: got %h expected %h", idx, exp_idx); end
    exp_idx++;
  endtask

  task automatic test_flush();
    logic [31:0]   ones [4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0]   d;
    logic [IW-1:0] idx;
    bit            to;
    send_term(32'h4100_0000, to);
    send_term(32'h4100_0000, to);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    send4(ones, to);
    repeat (2) begin
      @(negedge clk);
      flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h4080_0000) begin n_fail++; $display("FAIL flush_in_done: valid %b data %h expected 1 40800000", out_valid, out_data); end
    get_out(d, idx, to);
    n_checks++; if (to || d !== 32'h4080_0000) begin n_fail++; $display("FAIL flush_data: got %h expected 40800000", d); end
    n_checks++; if (idx !== exp_idx) begin n_fail++; $display("FAIL flush_idx: got %h expected %h", idx, exp_idx); end
    exp_idx++;
  endtask

  task automatic test_truncation();
    // 1.0 + 1.5*2^-24 truncates back to 1.0; (1+3ulp) + 2.0 truncates to 3.0 + 1ulp.
    logic [31:0]   ta [4] = '{32'h3F80_0000, 32'h33C0_0000, 32'h0, 32'h0};
    logic [31:0]   tb [4] = '{32'h3F80_0003, 32'h4000_0000, 32'h0, 32'h0};
    logic [31:0]   d;
    logic [IW-1:0] idx;
    bit            to;
    send4(ta, to);
    get_out(d, idx, to);
    n_checks++; if (to || d !== 32'h3F80_0000) begin n_fail++; $display("FAIL trunc_small: got %h expected 3f800000", d); end
    exp_idx++;
    send4(tb, to);
    get_out(d, idx, to);
    n_checks++; if (to || d !== 32'h4040_0001) begin n_fail++; $display("FAIL trunc_align: got %h expected 40400001", d); end
    n_checks++; if (idx !== exp_idx) begin n_fail++; $display("FAIL trunc_idx: got %h expected %h", idx, exp_idx); end
    exp_idx++;
  endtask

  task automatic test_reset_mid();
    logic [31:0]   ones [4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0]   d;
    logic [IW-1:0] idx;
    bit            to;
    for (int i = 0; i < 3; i++) send_term(32'h4000_0000, to);
    pulse_reset();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_state: valid %b ready %b expected 0 1", out_valid, in_ready); end
    send4(ones, to);
    get_out(d, idx, to);
    n_checks++; if (to || d !== 32'h4080_0000) begin n_fail++; $display("FAIL rstmid_data: got %h expected 40800000", d); end
    n_checks++; if (idx !== exp_idx) begin n_fail++; $display("FAIL rstmid_idx: got %h expected %h", idx, exp_idx); end
    exp_idx++;
    send4(ones, to);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstdone_pending: got %b expected 1", out_valid); end
    pulse_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out_idx !== exp_idx) begin n_fail++; $display("FAIL rstdone_lost: valid %b idx %h expected 0 %h", out_valid, out_idx, exp_idx); end
  endtask

  task automatic test_idx_wrap();
    logic [31:0]   t [4];
    logic [31:0]   d;
    logic [IW-1:0] idx;
    int unsigned   n;
    int unsigned   total;
    int            s;
    bit            to;
    int            bad;
    pulse_reset();
    bad = 0;
    for (int k = 0; k < 257; k++) begin
      s     = int'($urandom_range(0, 3));
      total = 0;
      for (int i = 0; i < 4; i++) begin
        n     = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4095);
        total = total + n;
        t[i]  = to_f32(n, s);
      end
      send4(t, to);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      get_out(d, idx, to);
      n_checks++;
      if (to || d !== to_f32(total, s) || idx !== exp_idx) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_dist %0d: data %h idx %h expected %h %h", k, d, idx, to_f32(total, s), exp_idx);
      end
      exp_idx++;
    end
    n_checks++; if (out_idx !== 8'h01) begin n_fail++; $display("FAIL idx_wrap: got %h expected 01", out_idx); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zeros();
    test_flush();
    test_truncation();
    test_reset_mid();
    test_idx_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
